// File: rtl/muldiv_issue_ctrl.sv
// Issue and interlock control between the EX stage and the MUL/DIV unit.
// It drives the unit's command strobes and stalls the pipeline on HI/LO hazards.
module muldiv_issue_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [3:0]       ex_cmd,
  input  logic             ex_flush,
  input  logic [31:0]      ex_rs,
  input  logic [31:0]      ex_rt,
  input  logic             md_busy,
  input  logic [31:0]      md_hi,
  input  logic [31:0]      md_lo,
  output logic             md_start,
  output logic [1:0]       md_op,
  output logic             md_we,
  output logic             md_hilo,
  output logic [31:0]      md_d1,
  output logic [31:0]      md_d2,
  output logic             stall,
  output logic [31:0]      mf_data,
  output logic             md_fault,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WC_W = $clog2(TIMEOUT + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t          state;
  logic [WC_W-1:0] waitCnt;
  logic            act;
  logic            isMd;
  logic            isMt;
  logic            hazard;
  logic [3:0]      opm;

  assign isMd = (ex_cmd >= 4'd1) && (ex_cmd <= 4'd4);
  assign isMt = (ex_cmd == 4'd5) || (ex_cmd == 4'd6);
  assign act  = ex_valid && !ex_flush
             && (ex_cmd >= 4'd1) && (ex_cmd <= 4'd8);

  // A MUL/DIV still waits in the RUN cycle where Busy falls, so it
  // issues from IDLE on the next cycle. A faulted unit no longer blocks.
  assign hazard = !md_fault
               && (md_busy || ((state == RUN) && isMd));

  assign stall    = act && hazard;
  assign md_start = act && isMd && !hazard && (state == IDLE);
  assign md_we    = act && isMt && !hazard;
  assign md_hilo  = (ex_cmd == 4'd5);

  assign opm   = ex_cmd - 4'd1;
  assign md_op = isMd ? opm[1:0] : 2'b00;

  assign md_d1   = ex_rs;
  assign md_d2   = ex_rt;
  assign mf_data = (ex_cmd == 4'd7) ? md_hi : md_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      waitCnt   <= '0;
      md_fault  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (stall) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (md_start) begin
            state   <= RUN;
            waitCnt <= '0;
          end
        end
        RUN: begin
          if (!md_busy) begin
            state <= IDLE;
          end else if (waitCnt == WC_W'(TIMEOUT - 1)) begin
            md_fault <= 1'b1;
            state    <= IDLE;
            waitCnt  <= '0;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Directed bench for muldiv_issue_ctrl with a behavioural MUL/DIV unit.
// The unit reports results when Busy falls: 11 cycles for MUL, 41 for DIV.
module tb_muldiv_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        exValid;
  logic [3:0]  exCmd;
  logic        exFlush;
  logic [31:0] exRs;
  logic [31:0] exRt;
  logic        mdBusy;
  logic [31:0] mdHi;
  logic [31:0] mdLo;
  logic        mdStart;
  logic [1:0]  mdOp;
  logic        mdWe;
  logic        mdHilo;
  logic [31:0] mdD1;
  logic [31:0] mdD2;
  logic        stall;
  logic [31:0] mfData;
  logic        mdFault;
  logic [31:0] stallCnt;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  muldiv_issue_ctrl #(.TIMEOUT(64), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(exValid), .ex_cmd(exCmd), .ex_flush(exFlush),
    .ex_rs(exRs), .ex_rt(exRt),
    .md_busy(mdBusy), .md_hi(mdHi), .md_lo(mdLo),
    .md_start(mdStart), .md_op(mdOp), .md_we(mdWe), .md_hilo(mdHilo),
    .md_d1(mdD1), .md_d2(mdD2),
    .stall(stall), .mf_data(mfData),
    .md_fault(mdFault), .stall_cnt(stallCnt)
  );

  int unsigned uCnt;
  logic        forceBusy;
  logic [31:0] pHi;
  logic [31:0] pLo;

  function automatic logic [63:0] mdResult(
    input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic [63:0] r;
    sa = $signed(a);
    sb = $signed(b);
    r = '0;
    case (op)
      2'b00: r = {32'b0, a} * {32'b0, b};
      2'b01: r = sa * sb;
      2'b10: if (b != 0) r = {a % b, a / b};
      default: if (b != 0) r = {32'($signed(a) % $signed(b)),
                                32'($signed(a) / $signed(b))};
    endcase
    return r;
  endfunction

  assign mdBusy = forceBusy || (uCnt != 0);

  always @(posedge clk) begin
    if (rst) begin
      uCnt <= 0;
      mdHi <= '0;
      mdLo <= '0;
    end else begin
      if (mdStart) begin
        uCnt <= mdOp[1] ? 41 : 11;
        {pHi, pLo} <= mdResult(mdOp, mdD1, mdD2);
      end else if (uCnt != 0) begin
        uCnt <= uCnt - 1;
        if (uCnt == 1) begin
          mdHi <= pHi;
          mdLo <= pLo;
        end
      end
      if (mdWe) begin
        if (mdHilo) mdHi <= mdD1;
        else        mdLo <= mdD1;
      end
    end
  end

  task automatic checkEq(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] c,
                       input logic f, input logic [31:0] rs,
                       input logic [31:0] rt);
    @(negedge clk);
    exValid = v;
    exCmd   = c;
    exFlush = f;
    exRs    = rs;
    exRt    = rt;
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  int n;
  int starts;
  int bad;
  logic lastFault;

  initial begin
    forceBusy = 1'b0;
    doReset();
    drive(0, 0, 0, 0, 0);
    checkEq("rst_start", mdStart, 0);
    checkEq("rst_we", mdWe, 0);
    checkEq("rst_stall", stall, 0);
    checkEq("rst_fault", mdFault, 0);
    checkEq("rst_cnt", stallCnt, 0);

    drive(1, 2, 0, 32'hFFFF_FFFD, 5);
    checkEq("mult_start", mdStart, 1);
    checkEq("mult_op", mdOp, 2'b01);
    checkEq("mult_nostall", stall, 0);
    checkEq("mult_d1", mdD1, 32'hFFFF_FFFD);
    checkEq("mult_d2", mdD2, 5);
    starts = 1;
    n = 0;
    drive(1, 8, 0, 0, 0);
    while (stall && n < 100) begin
      n++;
      if (mdStart) starts++;
      drive(1, 8, 0, 0, 0);
    end
    checkEq("mult_stall_len", n, 11);
    checkEq("mult_starts", starts, 1);
    checkEq("mult_mflo", mfData, 32'hFFFF_FFF1);
    drive(1, 7, 0, 0, 0);
    checkEq("mult_mfhi", mfData, 32'hFFFF_FFFF);
    checkEq("mult_cnt", stallCnt, 11);

    doReset();
    drive(0, 0, 0, 0, 0);
    checkEq("rst2_cnt", stallCnt, 0);
    drive(1, 3, 0, 100, 7);
    checkEq("divu_start", mdStart, 1);
    checkEq("divu_op", mdOp, 2'b10);
    n = 0;
    drive(1, 7, 0, 0, 0);
    while (stall && n < 100) begin
      n++;
      drive(1, 7, 0, 0, 0);
    end
    checkEq("divu_stall_len", n, 41);
    checkEq("divu_mfhi", mfData, 2);
    drive(1, 8, 0, 0, 0);
    checkEq("divu_mflo", mfData, 14);
    checkEq("divu_cnt", stallCnt, 41);

    drive(1, 6, 0, 32'h1234, 0);
    checkEq("mtlo_we", mdWe, 1);
    checkEq("mtlo_hilo", mdHilo, 0);
    checkEq("mtlo_stall", stall, 0);
    checkEq("mtlo_start", mdStart, 0);
    drive(1, 8, 0, 0, 0);
    checkEq("mtlo_mflo", mfData, 32'h1234);
    checkEq("mtlo_mflo_stall", stall, 0);
    drive(1, 5, 0, 32'hABCD, 0);
    checkEq("mthi_hilo", mdHilo, 1);
    drive(1, 7, 0, 0, 0);
    checkEq("mthi_mfhi", mfData, 32'hABCD);

    drive(1, 2, 0, 2, 3);
    checkEq("m4_start", mdStart, 1);
    bad = 0;
    drive(1, 0, 0, 0, 0);
    if (stall) bad++;
    drive(1, 9, 0, 0, 0);
    if (stall) bad++;
    drive(1, 15, 0, 0, 0);
    if (stall) bad++;
    checkEq("m4_alu_nostall", bad, 0);
    n = 0;
    starts = 0;
    drive(1, 1, 0, 6, 7);
    while (stall && n < 100) begin
      n++;
      if (mdStart) starts++;
      drive(1, 1, 0, 6, 7);
    end
    checkEq("m4_wait_len", n, 9);
    checkEq("m4_early_start", starts, 0);
    checkEq("m4_start2", mdStart, 1);
    checkEq("m4_op2", mdOp, 2'b00);
    n = 0;
    drive(1, 8, 0, 0, 0);
    while (stall && n < 100) begin
      n++;
      drive(1, 8, 0, 0, 0);
    end
    checkEq("m4_mflo_wait", n, 11);
    checkEq("m4_mflo", mfData, 42);

    drive(1, 2, 1, 9, 9);
    checkEq("flush_start", mdStart, 0);
    checkEq("flush_stall", stall, 0);
    drive(1, 8, 0, 0, 0);
    checkEq("flush_idle", stall, 0);
    checkEq("flush_lo", mfData, 42);

    drive(1, 4, 0, 32'hFFFF_FFF7, 2);
    checkEq("wd_start", mdStart, 1);
    checkEq("wd_op", mdOp, 2'b11);
    @(negedge clk);
    forceBusy = 1'b1;
    exCmd = 4'd7;
    #1;
    n = 0;
    lastFault = 1'b0;
    while (stall && n < 100) begin
      n++;
      lastFault = mdFault;
      drive(1, 7, 0, 0, 0);
    end
    checkEq("wd_stall_len", n, 64);
    checkEq("wd_fault_late", lastFault, 0);
    checkEq("wd_fault", mdFault, 1);
    checkEq("wd_released", stall, 0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 7, 0, 0, 0);
      if (stall || !mdFault) bad++;
    end
    checkEq("wd_sticky", bad, 0);
    forceBusy = 1'b0;
    doReset();
    drive(0, 0, 0, 0, 0);
    checkEq("end_start", mdStart, 0);
    checkEq("end_op", mdOp, 0);
    checkEq("end_we", mdWe, 0);
    checkEq("end_hilo", mdHilo, 0);
    checkEq("end_stall", stall, 0);
    checkEq("end_fault", mdFault, 0);
    checkEq("end_cnt", stallCnt, 0);
    checkEq("end_mf", mfData, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
